iter_muldiv: RTL

Parametrised multi-cycle unsigned multiply/divide unit with a start/busy/done handshake. It is the iterative successor to the fixed 32-bit shift-add multiplier and restoring divider. It sits beside the ALU and serves the multiply (`s=01`) and divide (`s=10`) opcodes when the combinational fast paths are too large or too slow. It adds full 2W-bit products, remainders, divide-by-zero flagging and a defined handshake.

---
 rtl/muldiv_pkg.sv | 7 +
 rtl/add_sub_w.sv | 29 ++
 rtl/full_adder.sv | 13 +
 rtl/iter_muldiv.sv | 127 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;
  typedef enum logic {MD_MUL, MD_DIV} md_op_t;

endpackage

// File: rtl/add_sub_w.sv
// N-bit ripple adder/subtractor; co is the carry out (not-borrow when subtracting).
module add_sub_w #(
  parameter int unsigned N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         co
);

  logic [N:0]   c;
  logic [N-1:0] b_eff;

  assign c[0]  = sub;
  assign b_eff = b ^ {N{sub}};
  assign co    = c[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b_eff[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) with start/busy/done handshake.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         r,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div_zero
);

  localparam int unsigned CW = $clog2(W) + 1;

  md_state_t      state, state_nx;
  md_op_t         op_q;
  logic [W-1:0]   y_q;
  logic [W-1:0]   q;
  logic [W:0]     acc;
  logic [CW-1:0]  cnt;
  logic           last;

  logic [W:0]     add_a, add_b, add_s;
  logic           add_co, add_sub;
  logic [W:0]     acc_nx;
  logic [W-1:0]   q_nx;

  assign last = (cnt == CW'(W - 1));
  assign busy = (state != MD_IDLE);
  assign done = (state == MD_DONE);

  always_ff @(posedge clk) begin
    if (r) state <= MD_IDLE;
    else   state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: if (start) state_nx = (op && (y == '0)) ? MD_DONE : MD_RUN;
      MD_RUN:  if (last)  state_nx = MD_DONE;
      MD_DONE: state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  // One adder serves both datapaths: acc is A for multiply and R for divide.
  always_comb begin
    add_sub = (op_q == MD_DIV);
    acc_nx  = acc;
    q_nx    = q;
    if (op_q == MD_DIV) begin
      add_a = {acc[W-1:0], q[W-1]};
      add_b = {1'b0, y_q};
      if (add_co) begin
        acc_nx = add_s;
        q_nx   = {q[W-2:0], 1'b1};
      end else begin
        acc_nx = add_a;
        q_nx   = {q[W-2:0], 1'b0};
      end
    end else begin
      add_a  = acc;
      add_b  = q[0] ? {1'b0, y_q} : '0;
      acc_nx = {1'b0, add_s[W:1]};
      q_nx   = {add_s[0], q[W-1:1]};
    end
  end

  add_sub_w #(.N(W + 1)) u_add (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_s),
    .co  (add_co)
  );

  always_ff @(posedge clk) begin
    if (r) begin
      op_q     <= MD_MUL;
      y_q      <= '0;
      q        <= '0;
      acc      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            op_q     <= md_op_t'(op);
            y_q      <= y;
            q        <= x;
            acc      <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
            if (op && (y == '0)) begin
              div_zero <= 1'b1;
              hi       <= x;
              lo       <= '1;
            end
          end
        end
        MD_RUN: begin
          acc <= acc_nx;
          q   <= q_nx;
          cnt <= cnt + 1'b1;
          // Results are registered on the last step so they are valid throughout DONE.
          if (last) begin
            hi <= acc_nx[W-1:0];
            lo <= q_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
